// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state enums, character ids and damage defaults
package game_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } health_state_t;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } deflect_state_t;

    localparam logic [1:0] CHARA_ID_DEFLECT = 2'd1;

    localparam logic [9:0] DEF_MAX_HEALTH      = 10'd200;
    localparam logic [9:0] DEF_BOMB_DAMAGE     = 10'd150;
    localparam logic [9:0] DEF_BOOM_DAMAGE     = 10'd100;
    localparam logic [9:0] DEF_INVULN_FRAMES   = 10'd30;
    localparam logic [9:0] DEF_DEFLECT_FRAMES  = 10'd120;
    localparam logic [9:0] DEF_COOLDOWN_FRAMES = 10'd300;

    // Health never wraps below zero.
    function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : 10'd0;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - 10-bit frame counter with sync clear and terminal-count flag
module frame_timer (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [9:0] limit,
    output logic       done
);

    logic [9:0] count;

    always_ff @(posedge frame_clk) begin
        if (Reset || clear) begin
            count <= 10'd0;
        end else if (enable) begin
            count <= count + 10'd1;
        end
    end

    // Terminal count is the last enabled frame of the window.
    assign done = enable && (count == (limit - 10'd1));

endmodule

// File: rtl/damage_receiver.sv
// rtl/damage_receiver.sv - per-character health, invulnerability and deflect control
module damage_receiver
    import game_pkg::*;
#(
    parameter logic [9:0] MAX_HEALTH      = DEF_MAX_HEALTH,
    parameter logic [9:0] BOMB_DAMAGE     = DEF_BOMB_DAMAGE,
    parameter logic [9:0] BOOM_DAMAGE     = DEF_BOOM_DAMAGE,
    parameter logic [9:0] INVULN_FRAMES   = DEF_INVULN_FRAMES,
    parameter logic [9:0] DEFLECT_FRAMES  = DEF_DEFLECT_FRAMES,
    parameter logic [9:0] COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [1:0] chara_id,
    input  logic       chara_direction,
    input  logic       press_deflect,
    input  logic       BOMB_hit,
    input  logic       BOOM_hit,
    output logic [9:0] health,
    output logic       deflect_left,
    output logic       deflect_right,
    output logic       invuln,
    output logic       dead,
    output logic       deflect_ready
);

    health_state_t  h_state, h_next;
    deflect_state_t d_state, d_next;
    logic [9:0]     health_next;
    logic           press_prev;

    logic inv_clear, inv_enable, inv_done;
    logic def_clear, def_enable, def_done;

    logic       hit;
    logic [9:0] damage;
    logic [9:0] hit_health;
    logic       trigger;

    assign hit        = BOMB_hit || BOOM_hit;
    assign damage     = BOMB_hit ? BOMB_DAMAGE : BOOM_DAMAGE;
    assign hit_health = sat_sub(health, damage);
    assign trigger    = press_deflect && !press_prev && (chara_id == CHARA_ID_DEFLECT);

    frame_timer u_invuln_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (inv_clear),
        .enable    (inv_enable),
        .limit     (INVULN_FRAMES),
        .done      (inv_done)
    );

    frame_timer u_deflect_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (def_clear),
        .enable    (def_enable),
        .limit     ((d_state == ACTIVE) ? DEFLECT_FRAMES : COOLDOWN_FRAMES),
        .done      (def_done)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            h_state    <= ALIVE;
            d_state    <= READY;
            health     <= MAX_HEALTH;
            press_prev <= 1'b0;
        end else begin
            h_state    <= h_next;
            d_state    <= d_next;
            health     <= health_next;
            press_prev <= press_deflect;
        end
    end

    always_comb begin
        h_next      = h_state;
        health_next = health;
        inv_clear   = 1'b0;
        inv_enable  = 1'b0;
        case (h_state)
            ALIVE: begin
                if (hit) begin
                    health_next = hit_health;
                    h_next      = (hit_health == 10'd0) ? DEAD : INVULN;
                    inv_clear   = 1'b1;
                end
            end
            INVULN: begin
                inv_enable = 1'b1;
                if (inv_done) begin
                    h_next = ALIVE;
                end
            end
            default: begin
                h_next = DEAD;
            end
        endcase
    end

    // Death (entering or staying) parks the deflect FSM in READY with a clean counter.
    always_comb begin
        d_next     = d_state;
        def_clear  = 1'b0;
        def_enable = 1'b0;
        if (h_next == DEAD) begin
            d_next    = READY;
            def_clear = 1'b1;
        end else begin
            case (d_state)
                READY: begin
                    if (trigger) begin
                        d_next    = ACTIVE;
                        def_clear = 1'b1;
                    end
                end
                ACTIVE: begin
                    def_enable = 1'b1;
                    if (def_done) begin
                        d_next    = COOLDOWN;
                        def_clear = 1'b1;
                    end
                end
                COOLDOWN: begin
                    def_enable = 1'b1;
                    if (def_done) begin
                        d_next    = READY;
                        def_clear = 1'b1;
                    end
                end
                default: begin
                    d_next    = READY;
                    def_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        invuln        = (h_state == INVULN);
        dead          = (h_state == DEAD);
        deflect_left  = (d_state == ACTIVE) && !chara_direction;
        deflect_right = (d_state == ACTIVE) && chara_direction;
        deflect_ready = (d_state == READY) && (chara_id == CHARA_ID_DEFLECT) && (h_state != DEAD);
    end

endmodule
